// File: rtl/final_state_array.sv
`default_nettype none
// ============================================================================
//  Module   : final_state_array
//  Purpose  : Array of NUM_CH independent channel FSMs (IDLE/BUSY/DONE/ERR)
//             with a per-channel BUSY timeout and an aggregate done pulse
//             over the masked channels.
//  Ports    : clk, rst_n (async, active-low)
//             start_i, done_i, clr_i, mask_i  [NUM_CH]  per-channel controls
//             idle_o      all channels IDLE
//             done_o      one-cycle pulse on rise of aggregate done
//             ch_busy_o / ch_done_o / ch_err_o [NUM_CH] state decodes
//             done_cnt_o  number of channels in DONE (mask ignored)
//  Revision : 1.0  initial release
// ============================================================================
module final_state_array #(
   parameter int NUM_CH  = 4,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            start_i,
   input  logic [NUM_CH-1:0]            done_i,
   input  logic [NUM_CH-1:0]            clr_i,
   input  logic [NUM_CH-1:0]            mask_i,
   output logic                         idle_o,
   output logic                         done_o,
   output logic [NUM_CH-1:0]            ch_busy_o,
   output logic [NUM_CH-1:0]            ch_done_o,
   output logic [NUM_CH-1:0]            ch_err_o,
   output logic [$clog2(NUM_CH+1)-1:0]  done_cnt_o
);

   localparam int CNT_W = $clog2(NUM_CH+1);

   // Terminal timer value; unused when TIMEOUT is 0 (timeout disabled).
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
   localparam logic            TO_EN   = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   logic [NUM_CH-1:0] ch_idle;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         state_t          state, next_state;
         logic [TO_W-1:0] timer, timer_next;
         logic            timeout_hit;

         assign timeout_hit = TO_EN && (timer == TO_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state <= S_IDLE;
               timer <= '0;
            end else begin
               state <= next_state;
               timer <= timer_next;
            end
         end

         always_comb begin
            next_state = state;
            timer_next = timer;
            unique case (state)
               S_IDLE: begin
                  if (start_i[g] && !clr_i[g]) begin
                     next_state = S_BUSY;
                     timer_next = '0;
                  end
               end
               S_BUSY: begin
                  // done wins over a coincident timeout hit
                  if (clr_i[g])          next_state = S_IDLE;
                  else if (done_i[g])    next_state = S_DONE;
                  else if (timeout_hit)  next_state = S_ERR;
                  else                   timer_next = timer + 1'b1;
               end
               S_DONE: begin
                  if (clr_i[g]) begin
                     next_state = S_IDLE;
                  end else if (start_i[g]) begin
                     next_state = S_BUSY;
                     timer_next = '0;
                  end
               end
               S_ERR: begin
                  if (clr_i[g]) next_state = S_IDLE;
               end
               default: next_state = S_IDLE;
            endcase
         end

         assign ch_idle[g]   = (state == S_IDLE);
         assign ch_busy_o[g] = (state == S_BUSY);
         assign ch_done_o[g] = (state == S_DONE);
         assign ch_err_o[g]  = (state == S_ERR);
      end
   endgenerate

   assign idle_o = &ch_idle;

   always_comb begin
      done_cnt_o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         done_cnt_o = done_cnt_o + CNT_W'(ch_done_o[i]);
      end
   end

   // Aggregate done: an empty mask never counts as done.
   logic all_done, all_done_reg;

   assign all_done = (mask_i != '0) && ((ch_done_o & mask_i) == mask_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) all_done_reg <= 1'b0;
      else        all_done_reg <= all_done;
   end

   // Combinational rise detect so a mask change pulses in the same cycle.
   assign done_o = all_done & ~all_done_reg;

endmodule
`default_nettype wire

// File: tb/tb_final_state_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_final_state_array
//  Purpose  : Directed self-checking bench for final_state_array
//             (NUM_CH=4, TIMEOUT=10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_final_state_array;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] start_i, done_i, clr_i, mask_i;
   logic       idle_o, done_o;
   logic [3:0] ch_busy_o, ch_done_o, ch_err_o;
   logic [2:0] done_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   final_state_array #(
      .NUM_CH  (4),
      .TO_W    (16),
      .TIMEOUT (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .done_i     (done_i),
      .clr_i      (clr_i),
      .mask_i     (mask_i),
      .idle_o     (idle_o),
      .done_o     (done_o),
      .ch_busy_o  (ch_busy_o),
      .ch_done_o  (ch_done_o),
      .ch_err_o   (ch_err_o),
      .done_cnt_o (done_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, ".idle"}, 32'(idle_o), 32'd1);
      check({tag, ".done"}, 32'(done_o), 32'd0);
      check({tag, ".busy"}, 32'(ch_busy_o), 32'd0);
      check({tag, ".chdn"}, 32'(ch_done_o), 32'd0);
      check({tag, ".err"},  32'(ch_err_o), 32'd0);
      check({tag, ".cnt"},  32'(done_cnt_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_i = '0; done_i = '0; clr_i = '0; mask_i = '0;
      #3;
      check_reset_outs("rst");
      // inputs ignored under reset
      start_i = 4'b1111;
      tick();
      check("rst_ign.busy", 32'(ch_busy_o), 32'd0);
      start_i = '0;
      #2 rst_n = 1'b1;

      // Idle hold for 10 cycles
      for (int c = 0; c < 10; c++) begin
         tick();
         check("hold.idle", 32'(idle_o), 32'd1);
         check("hold.done", 32'(done_o), 32'd0);
         check("hold.cnt",  32'(done_cnt_o), 32'd0);
      end

      // All four channels, done at cycles 3,5,5,8
      mask_i  = 4'b1111;
      start_i = 4'b1111;
      tick();
      check("agg.busy", 32'(ch_busy_o), 32'hf);
      check("agg.idle0", 32'(idle_o), 32'd0);
      start_i = '0;
      for (int c = 1; c <= 9; c++) begin
         done_i = (c == 3) ? 4'b0001 : (c == 5) ? 4'b0110 : (c == 8) ? 4'b1000 : 4'b0000;
         tick();
         check("agg.cnt",  32'(done_cnt_o), (c < 3) ? 32'd0 : (c < 5) ? 32'd1 : (c < 8) ? 32'd3 : 32'd4);
         check("agg.done", 32'(done_o), (c == 8) ? 32'd1 : 32'd0);
         check("agg.idle", 32'(idle_o), 32'd0);
      end
      done_i = '0;
      clr_i  = 4'b1111;
      tick();
      clr_i  = '0;
      check("clrall.idle", 32'(idle_o), 32'd1);
      check("clrall.done", 32'(done_o), 32'd0);

      // Timeout on ch0
      start_i = 4'b0001;
      tick();
      start_i = '0;
      check("to.busy0", 32'(ch_busy_o), 32'h1);
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("to.busy", 32'(ch_busy_o), 32'h1);
         check("to.noerr", 32'(ch_err_o), 32'h0);
      end
      tick();
      check("to.err",  32'(ch_err_o), 32'h1);
      check("to.nobz", 32'(ch_busy_o), 32'h0);
      done_i = 4'b0001;
      tick();
      done_i = '0;
      check("to.err_hold", 32'(ch_err_o), 32'h1);
      check("to.no_done",  32'(ch_done_o), 32'h0);
      clr_i = 4'b0001;
      tick();
      clr_i = '0;
      check("to.clr_idle", 32'(idle_o), 32'd1);
      check("to.clr_err",  32'(ch_err_o), 32'h0);

      // done coincident with timeout hit
      start_i = 4'b0001;
      tick();
      start_i = '0;
      for (int k = 1; k <= 9; k++) tick();
      check("tie.pre_busy", 32'(ch_busy_o), 32'h1);
      done_i = 4'b0001;
      tick();
      done_i = '0;
      check("tie.done", 32'(ch_done_o), 32'h1);
      check("tie.err",  32'(ch_err_o), 32'h0);
      clr_i = 4'b1111;
      tick();
      clr_i = '0;

      // Masked aggregate, re-arm, mask-driven pulse, clr-over-start
      mask_i  = 4'b0011;
      start_i = 4'b0011;
      tick();
      start_i = '0;
      done_i  = 4'b0011;
      tick();
      done_i  = '0;
      check("msk.done",   32'(done_o), 32'd1);
      check("msk.chdn",   32'(ch_done_o), 32'h3);
      check("msk.busy",   32'(ch_busy_o), 32'h0);
      check("msk.err",    32'(ch_err_o), 32'h0);
      tick();
      check("msk.single", 32'(done_o), 32'd0);
      clr_i = 4'b0010;
      tick();
      clr_i = '0;
      check("msk.clr1",   32'(ch_done_o), 32'h1);
      check("msk.clr1dn", 32'(done_o), 32'd0);
      start_i = 4'b0010;
      tick();
      start_i = '0;
      check("msk.rebusy", 32'(ch_busy_o), 32'h2);
      done_i = 4'b0010;
      tick();
      done_i = '0;
      check("msk.rearm", 32'(done_o), 32'd1);
      check("msk.cnt",   32'(done_cnt_o), 32'd2);
      tick();
      check("msk.rearm_end", 32'(done_o), 32'd0);
      mask_i = 4'b0111;
      tick();
      check("mchg.off", 32'(done_o), 32'd0);
      mask_i = 4'b0011;
      #1;
      check("mchg.comb", 32'(done_o), 32'd1);
      tick();
      check("mchg.end", 32'(done_o), 32'd0);
      clr_i   = 4'b0101;
      start_i = 4'b0101;
      tick();
      clr_i   = '0;
      start_i = '0;
      check("cs.chdn", 32'(ch_done_o), 32'h2);
      check("cs.busy", 32'(ch_busy_o), 32'h0);
      clr_i = 4'b1111;
      tick();
      clr_i = '0;

      // Asynchronous reset between edges with two channels busy
      start_i = 4'b0011;
      tick();
      start_i = '0;
      check("ar.busy", 32'(ch_busy_o), 32'h3);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check_reset_outs("ar");
      #2 rst_n = 1'b1;
      tick();
      check("ar.post_idle", 32'(idle_o), 32'd1);
      start_i = 4'b0001;
      tick();
      start_i = '0;
      check("ar.first", 32'(ch_busy_o), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/final_state_array.md
FINAL_STATE_ARRAY -- requirements
Module: final_state_array

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent channels (1..32).
REQ-002 The block SHALL have parameter TO_W, default 16, giving the width of each channel timeout counter.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, giving the BUSY cycles allowed before error; 0 disables timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start_i, input, NUM_CH bits: per-channel start request, level-sampled each cycle.
REQ-007 The block SHALL have port done_i, input, NUM_CH bits: per-channel completion indication.
REQ-008 The block SHALL have port clr_i, input, NUM_CH bits: per-channel clear/abort.
REQ-009 The block SHALL have port mask_i, input, NUM_CH bits: channels that participate in the aggregate done.
REQ-010 The block SHALL have port idle_o, output, 1 bit: all channels in IDLE.
REQ-011 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when the aggregate done condition rises.
REQ-012 The block SHALL have ports ch_busy_o, ch_done_o and ch_err_o, each output, NUM_CH bits: per-channel decode of BUSY, DONE and ERR.
REQ-013 The block SHALL have port done_cnt_o, output, $clog2(NUM_CH+1) bits: count of channels in DONE, mask ignored.

Function
REQ-014 Each channel SHALL run an independent four-state FSM: IDLE, BUSY, DONE, ERR.
REQ-015 IDLE transitions: start_i=1 and clr_i=0 -> BUSY with timer cleared to 0; otherwise stay; done_i ignored.
REQ-016 BUSY transitions, by priority: clr_i -> IDLE; done_i -> DONE; TIMEOUT!=0 and timer==TIMEOUT-1 -> ERR; else timer+1 and stay; start_i ignored.
REQ-017 When done_i and the timeout hit occur in the same BUSY cycle, the channel SHALL go to DONE.
REQ-018 DONE transitions: clr_i -> IDLE; else start_i -> BUSY with timer cleared; else stay; done_i ignored.
REQ-019 ERR transitions: clr_i -> IDLE only; start_i and done_i ignored.
REQ-020 clr_i SHALL take priority over start_i in every state.
REQ-021 The timer SHALL increment only in BUSY, SHALL be TO_W bits, and SHALL NOT wrap, because TIMEOUT <= 2^TO_W is a legal parameter constraint.
REQ-022 A state change SHALL be visible on ch_*_o, idle_o and done_cnt_o one cycle after the input is sampled; these outputs SHALL be pure decodes of state registers.
REQ-023 all_done SHALL be 1 when mask_i is nonzero and every channel with mask_i=1 is in DONE; all-zero mask SHALL give all_done=0.
REQ-024 all_done_q SHALL be all_done registered; done_o SHALL be all_done AND NOT all_done_q, giving exactly one pulse per rising edge of all_done.
REQ-025 A mask_i change that makes all_done rise SHALL pulse done_o combinationally in that cycle.
REQ-026 A channel leaving DONE then re-entering DONE SHALL re-arm done_o.
REQ-027 idle_o SHALL be 1 exactly when all NUM_CH channels are in IDLE, regardless of mask_i.

Reset
REQ-028 On rst_n=0, all channels SHALL go to IDLE immediately and asynchronously, mid-operation included.
REQ-029 On rst_n=0, timers and all_done_q SHALL be 0.
REQ-030 On rst_n=0, the outputs SHALL be idle_o=1, done_o=0, ch_busy_o=0, ch_done_o=0, ch_err_o=0 and done_cnt_o=0.
REQ-031 Inputs SHALL be ignored while rst_n=0; the first transition SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 Bench SHALL cover: reset release with all inputs 0 -> idle_o=1, done_o=0, done_cnt_o=0 held for 10 cycles.
REQ-033 Bench SHALL cover: NUM_CH=4, mask=4'b1111, start all at cycle 0, done_i channels 0..3 at cycles 3,5,5,8 -> done_cnt_o steps 1,3,4; single done_o pulse at cycle 9; idle_o=0 throughout.
REQ-034 Bench SHALL cover: TIMEOUT=10, start ch0 and hold done_i=0 -> ch_busy_o[0]=1 for 10 cycles, then ch_err_o[0]=1; a later done_i has no effect; clr_i -> idle_o=1 next cycle.
REQ-035 Bench SHALL cover: done_i on the same cycle as timeout hit -> ch_done_o=1 and ch_err_o=0.
REQ-036 Bench SHALL cover: mask=4'b0011, ch0 and ch1 done -> done_o pulse while ch2 and ch3 stay IDLE; clr ch1 then restart and re-done -> second done_o pulse; clr_i with start_i on the same cycle -> IDLE.
REQ-037 Bench SHALL cover: rst_n asserted asynchronously between edges while 2 channels are BUSY -> all outputs reach reset values before the next edge.
